mul_div_unit: RTL and testbench

//  Parametrised multi-cycle RV32M multiply/divide unit. It sits in the execute stage next to the ALU.
//  It takes operands on a start/ready handshake and iterates one bit per cycle.
//  It pulses done with a registered result and a zero flag.
//  The pipeline stalls on ~ready or while a result is pending.

---
 rtl/mul_div_unit.sv | 198 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M multiply/divide unit: one iteration per cycle, registered result with done pulse.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle product and skip the iterative phase.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [2:0]       op_q, op_nx;
    logic             neg_q, neg_nx;
    logic [WIDTH-1:0] hi_q, hi_nx, lo_q, lo_nx, opb_q, opb_nx;
    logic             ready_nx, done_nx, zero_nx;
    logic [WIDTH-1:0] out_nx;

    logic             signed_a, signed_b, a_neg, b_neg, is_div, special;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_trial;
    logic [2*WIDTH-1:0] prod_abs, prod_fin;
    logic [WIDTH-1:0] quo_fin, rem_fin, res;

    // Operand conditioning at the accept edge: magnitudes and short-circuit detection
    always_comb begin
        signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = signed_a & a[WIDTH-1];
        b_neg    = signed_b & b[WIDTH-1];
        mag_a    = a_neg ? (~a + WIDTH'(1)) : a;
        mag_b    = b_neg ? (~b + WIDTH'(1)) : b;
        is_div   = op[2];
        special  = is_div && ((b == '0) || (!op[0] && (a == MIN_VAL) && (b == '1)));
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {WIDTH'(0), mag_a} * {WIDTH'(0), mag_b};
`endif

    // One shift-add (multiply, {hi,lo} shifts right) or restoring step (divide, lo is dividend/quotient)
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opb_q};
    end

    // Sign fix-up and result selection in FIN
    always_comb begin
        prod_abs = {hi_q, lo_q};
        prod_fin = neg_q ? (~prod_abs + (2*WIDTH)'(1)) : prod_abs;
        quo_fin  = neg_q ? (~lo_q + WIDTH'(1)) : lo_q;
        rem_fin  = neg_q ? (~hi_q + WIDTH'(1)) : hi_q;
        case (op_q)
            OP_MUL:                       res = prod_fin[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod_fin[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              res = quo_fin;
            default:                      res = rem_fin;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_nx    = op_q;
        neg_nx   = neg_q;
        hi_nx    = hi_q;
        lo_nx    = lo_q;
        opb_nx   = opb_q;
        out_nx   = out;
        zero_nx  = zero;
        done_nx  = 1'b0;

        if (flush) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && ready) begin
                        op_nx    = op;
                        cnt_nx   = CW'(WIDTH-1);
                        state_nx = CALC;
                        hi_nx    = '0;
                        case (op)
                            OP_MULH:   neg_nx = a_neg ^ b_neg;
                            OP_MULHSU: neg_nx = a_neg;
                            OP_DIV:    neg_nx = a_neg ^ b_neg;
                            OP_REM:    neg_nx = a_neg;
                            default:   neg_nx = 1'b0;
                        endcase
                        if (is_div) begin
                            lo_nx  = mag_a;
                            opb_nx = mag_b;
                        end else begin
                            lo_nx  = mag_b;
                            opb_nx = mag_a;
                        end
                        // Precomputed results land in the quotient (lo) and remainder (hi) slots
                        if (special) begin
                            state_nx = FIN;
                            neg_nx   = 1'b0;
                            if (b == '0) begin
                                lo_nx = '1;
                                hi_nx = a;
                            end else begin
                                lo_nx = MIN_VAL;
                                hi_nx = '0;
                            end
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!is_div) begin
                            {hi_nx, lo_nx} = fast_prod;
                            state_nx       = FIN;
                        end
`endif
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        if (!div_trial[WIDTH]) begin
                            hi_nx = div_trial[WIDTH-1:0];
                            lo_nx = {lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_nx = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                            lo_nx = {lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        hi_nx = mul_sum[WIDTH:1];
                        lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
                    end
                    if (cnt == '0) state_nx = FIN;
                    else           cnt_nx   = cnt - CW'(1);
                end
                FIN: begin
                    out_nx   = res;
                    zero_nx  = ~|res;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end

        // ready stays low through the done cycle so a start there is not taken
        ready_nx = (state_nx == IDLE) && !done_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
            opb_q <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            out   <= '0;
            zero  <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            op_q  <= op_nx;
            neg_q <= neg_nx;
            hi_q  <= hi_nx;
            lo_q  <= lo_nx;
            opb_q <= opb_nx;
            ready <= ready_nx;
            done  <= done_nx;
            out   <= out_nx;
            zero  <= zero_nx;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: cycle-level reference model with per-cycle compare plus directed vectors.
module tb_mul_div_unit;

    localparam int unsigned WIDTH = 32;
    localparam logic [31:0] MIN_VAL = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        ready, done, zero;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
        .a(a), .b(b), .ready(ready), .done(done), .out(out), .zero(zero)
    );

    always #5 clk = ~clk;

    // RV32M reference results from plain 64-bit arithmetic
    function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        longint sx, sy, q;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == MIN_VAL && y == 32'hFFFF_FFFF) return MIN_VAL;
                q = sx / sy; return 32'(q);
            end
            3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 32'd0) return x;
                if (x == MIN_VAL && y == 32'hFFFF_FFFF) return 32'd0;
                q = sx % sy; return 32'(q);
            end
            default: return (y == 32'd0) ? x : x % y;
        endcase
    endfunction

    // Edges from accept to the edge after which done is high
    function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && (y == 32'd0 || (!o[0] && x == MIN_VAL && y == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!o[2]) return 1;
`endif
        return WIDTH + 1;
    endfunction

    // Reference handshake model: countdown to done, ready low through done cycle
    logic        m_ready = 1'b1, m_done = 1'b0, m_zero = 1'b1;
    logic [31:0] m_out = 32'd0, m_res = 32'd0;
    int          m_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready = 1'b1; m_done = 1'b0; m_out = 32'd0; m_zero = 1'b1; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            if (flush) begin
                m_cnt = 0; m_ready = 1'b1;
            end else if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_done = 1'b1; m_out = m_res; m_zero = (m_res == 32'd0); m_ready = 1'b0;
                end
            end else if (m_ready && start) begin
                m_res = model_res(op, a, b); m_cnt = model_lat(op, a, b); m_ready = 1'b0;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        checks++;
        if (ready !== m_ready || done !== m_done || out !== m_out || zero !== m_zero) begin
            errors++;
            $display("FAIL cycle_model t=%0t actual rdy=%b done=%b out=%h zero=%b required rdy=%b done=%b out=%h zero=%b",
                     $time, ready, done, out, zero, m_ready, m_done, m_out, m_zero);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) chk("wait_ready_timeout", 64'(ready), 64'd1);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_v, input int exp_l, input string name);
        int  lat = 0;
        bit  got = 1'b0;
        wait_ready();
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin lat = k; got = 1'b1; break; end
        end
        chk({name, "_latency"}, 64'(got ? lat : -1), 64'(exp_l));
        chk({name, "_out"}, 64'(out), 64'(exp_v));
        chk({name, "_zero"}, 64'(zero), 64'(exp_v == 32'd0));
    endtask

    int lmul, lnorm, d0;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    initial begin
        lnorm = WIDTH + 1;
`ifdef MULDIV_FAST_MUL_EN
        lmul = 1;
`else
        lmul = WIDTH + 1;
`endif
        rst = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_out", 64'(out), 64'd0);
        chk("reset_zero", 64'(zero), 64'd1);
        @(negedge clk) rst = 1'b0;

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, lmul, "mul_7_m3");

        // async reset in the middle of a divide
        wait_ready();
        start = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ready", 64'(ready), 64'd1);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_out", 64'(out), 64'd0);
        chk("midrst_zero", 64'(zero), 64'd1);
        @(negedge clk) rst = 1'b0;
        do_op(3'd5, 32'd1000, 32'd7, 32'd142, lnorm, "divu_after_rst");

        do_op(3'd1, MIN_VAL, 32'hFFFF_FFFF, 32'h0000_0000, lmul, "mulh");
        do_op(3'd2, MIN_VAL, 32'hFFFF_FFFF, 32'h8000_0000, lmul, "mulhsu");
        do_op(3'd3, MIN_VAL, 32'hFFFF_FFFF, 32'h7FFF_FFFF, lmul, "mulhu");

        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, lnorm, "div_m7_2");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, lnorm, "rem_m7_2");
        do_op(3'd5, 32'd100, 32'd7, 32'd14, lnorm, "divu_100_7");
        do_op(3'd7, 32'd100, 32'd7, 32'd2, lnorm, "remu_100_7");

        // flush at CALC cycle 10: no done, ready next cycle, out keeps 2
        wait_ready();
        d0 = done_cnt;
        start = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_ready", 64'(ready), 64'd1);
        chk("flush_done", 64'(done), 64'd0);
        chk("flush_out", 64'(out), 64'd2);
        repeat (40) @(posedge clk);
        #1 chk("flush_no_done", 64'(done_cnt - d0), 64'd0);

        do_op(3'd4, 32'd12345, 32'd0, 32'hFFFF_FFFF, 1, "div_by0");
        do_op(3'd6, 32'd5, 32'd0, 32'd5, 1, "rem_5_by0");
        do_op(3'd4, MIN_VAL, 32'hFFFF_FFFF, MIN_VAL, 1, "div_ovf");
        do_op(3'd6, MIN_VAL, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
        do_op(3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
        do_op(3'd7, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1, "remu_by0");

        // start held through busy: accepts at N0, N0+35, N0+70 -> three dones
        wait_ready();
        d0 = done_cnt;
        start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
        @(posedge clk);
        repeat (70) @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #1 chk("held_start_dones", 64'(done_cnt - d0), 64'd3);

        // flush with start in IDLE must not accept
        wait_ready();
        start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'd50; b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        chk("flush_start_ready", 64'(ready), 64'd1);
        chk("flush_start_out", 64'(out), 64'd14);

        for (int i = 0; i < 8; i++) begin
            ro = 3'(i);
            ra = $urandom;
            rb = (i == 5) ? 32'd3 : $urandom;
            do_op(ro, ra, rb, model_res(ro, ra, rb), model_lat(ro, ra, rb), "rand_op");
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
